// File: rtl/i2s_rx_deserializer_if.sv
// I2S receive bus: serial line in, 16-bit sample strobe out.
// master drives the line, slave is the deserializer.
interface i2s_rx_deserializer_if #(
  parameter int PKT_WIDTH = 16
);
  logic                 ws;
  logic                 sd;
  logic [PKT_WIDTH-1:0] pkt;
  logic                 pktChanged;
  logic                 synced;
  logic                 frameErr;

  modport master (
    output ws,
    output sd,
    input  pkt,
    input  pktChanged,
    input  synced,
    input  frameErr
  );

  modport slave (
    input  ws,
    input  sd,
    output pkt,
    output pktChanged,
    output synced,
    output frameErr
  );
endinterface

// File: rtl/i2s_rx_deserializer.sv
// Standard-I2S receiver: BCLK-domain deserializer, one strobe per frame.
// Option I2S_RX_STEREO_AVG_EN: emit (L+R)>>>1 instead of the left word.
module i2s_rx_deserializer #(
  parameter int PKT_WIDTH  = 16,
  parameter int SLOT_WIDTH = 16
) (
  input logic                  clk_i,
  input logic                  rst_n_i,
  i2s_rx_deserializer_if.slave rx
);
  localparam int CW = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(SLOT_WIDTH - 1);

  typedef enum logic {
    SYNC,
    SHIFT
  } state_t;

  state_t               state;
  state_t               stateN;
  logic [CW-1:0]        bitCnt;
  logic [CW-1:0]        bitCntN;
  logic [PKT_WIDTH-1:0] shReg;
  logic [PKT_WIDTH-1:0] shRegN;
  logic [PKT_WIDTH-1:0] word;
  logic [PKT_WIDTH-1:0] pktQ;
  logic [PKT_WIDTH-1:0] pktN;
  logic                 wsQ;
  logic                 stbQ;
  logic                 stbN;
  logic                 syncQ;
  logic                 syncN;
  logic                 errQ;
  logic                 errN;
  logic                 toggle;
  logic                 lastBit;
  logic                 shiftEn;
`ifdef I2S_RX_STEREO_AVG_EN
  logic [PKT_WIDTH-1:0]        leftHold;
  logic [PKT_WIDTH-1:0]        leftHoldN;
  logic                        leftValid;
  logic                        leftValidN;
  logic signed [PKT_WIDTH:0]   sum;
  logic [PKT_WIDTH-1:0]        avg;

  assign sum = $signed({leftHold[PKT_WIDTH-1], leftHold})
             + $signed({word[PKT_WIDTH-1], word});
  assign avg = PKT_WIDTH'(sum >>> 1);
`endif

  assign toggle  = rx.ws ^ wsQ;
  assign lastBit = (bitCnt == LAST);
  assign shiftEn = (32'(bitCnt) < PKT_WIDTH);
  assign word    = shiftEn ? {shReg[PKT_WIDTH-2:0], rx.sd} : shReg;

  assign rx.pkt        = pktQ;
  assign rx.pktChanged = stbQ;
  assign rx.synced     = syncQ;
  assign rx.frameErr   = errQ;

  // framing state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= SYNC;
    else          state <= stateN;
  end

  // next-state, slot accounting and output selection
  always_comb begin
    stateN  = state;
    bitCntN = bitCnt;
    shRegN  = shReg;
    pktN    = pktQ;
    stbN    = 1'b0;
    syncN   = syncQ;
    errN    = errQ;
`ifdef I2S_RX_STEREO_AVG_EN
    leftHoldN  = leftHold;
    leftValidN = leftValid;
`endif
    unique case (state)
      SYNC: begin
        if (toggle) begin
          stateN  = SHIFT;
          bitCntN = '0;
          syncN   = 1'b1;
        end
      end
      SHIFT: begin
        shRegN = word;
        unique case (1'b1)
          toggle && lastBit: begin
            bitCntN = '0;
`ifdef I2S_RX_STEREO_AVG_EN
            if (!wsQ) begin
              leftHoldN  = word;
              leftValidN = 1'b1;
            end else if (leftValid) begin
              pktN       = avg;
              stbN       = 1'b1;
              leftValidN = 1'b0;
            end
`else
            if (!wsQ) begin
              pktN = word;
              stbN = 1'b1;
            end
`endif
          end
          toggle && !lastBit: begin
            errN    = 1'b1;
            bitCntN = '0;
`ifdef I2S_RX_STEREO_AVG_EN
            leftValidN = 1'b0;
`endif
          end
          !toggle && lastBit: begin
            errN    = 1'b1;
            syncN   = 1'b0;
            stateN  = SYNC;
            bitCntN = '0;
`ifdef I2S_RX_STEREO_AVG_EN
            leftValidN = 1'b0;
`endif
          end
          default: bitCntN = bitCnt + CW'(1);
        endcase
      end
      default: stateN = SYNC;
    endcase
  end

  // datapath and output registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bitCnt <= '0;
      shReg  <= '0;
      wsQ    <= 1'b0;
      pktQ   <= '0;
      stbQ   <= 1'b0;
      syncQ  <= 1'b0;
      errQ   <= 1'b0;
    end else begin
      bitCnt <= bitCntN;
      shReg  <= shRegN;
      wsQ    <= rx.ws;
      pktQ   <= pktN;
      stbQ   <= stbN;
      syncQ  <= syncN;
      errQ   <= errN;
    end
  end

`ifdef I2S_RX_STEREO_AVG_EN
  // held left word awaiting its right partner
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      leftHold  <= '0;
      leftValid <= 1'b0;
    end else begin
      leftHold  <= leftHoldN;
      leftValid <= leftValidN;
    end
  end
`endif
endmodule
